// File: rtl/serial_latch_pkg.sv
// serial_latch_loader shared types, word size and counter sizing.
// Word size grows to 5 when SERIAL_LATCH_PARITY_EN is defined.
package serial_latch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE_LO,
    GAP,
    STROBE_HI,
    HOLD
  } state_t;

`ifdef SERIAL_LATCH_PARITY_EN
  localparam int WORD_BITS = 5;
`else
  localparam int WORD_BITS = 4;
`endif

  localparam int BIT_CNT_W = $clog2(WORD_BITS);

  function automatic int STROBE_CNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_latch_loader_strobe_timer.sv
// strobe_timer: loadable down-counter that stops at zero.
// Shared by both enable-pulse states of the loader.
module strobe_timer
  import serial_latch_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // load on state entry, then count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/serial_latch_loader.sv
// serial_latch_loader: serial-to-4-bit feeder for a dual-enable latch.
// Define SERIAL_LATCH_PARITY_EN for 5-bit words with even parity and err.
module serial_latch_loader
  import serial_latch_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sdi,
  input  logic sdi_valid,
  output logic sdi_ready,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic c1,
  output logic c2,
  output logic done
`ifdef SERIAL_LATCH_PARITY_EN
  ,
  output logic err
`endif
);

  localparam int CNT_W = STROBE_CNT_W(STROBE_CYCLES);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_w
    $error("STROBE_CYCLES must be in 1..15");
  end

  state_t r_state;
  state_t w_next;

  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [WORD_BITS-2:0] r_shift;
  logic [3:0]           r_d;
  logic                 r_ready;
  logic                 r_c1;
  logic                 r_c2;
  logic                 r_done;

  logic       w_accept;
  logic       w_last;
  logic       w_par_ok;
  logic [3:0] w_word;
  logic       w_expired;
  logic       w_tmr_load;
  logic       w_tmr_dec;

  assign w_accept = sdi_valid && (r_state == IDLE);
  assign w_last   = w_accept &&
                    (r_bit_cnt == BIT_CNT_W'(WORD_BITS - 1));

`ifdef SERIAL_LATCH_PARITY_EN
  logic r_err;

  assign w_word   = r_shift;
  assign w_par_ok = ((^r_shift) == sdi);

  // one-cycle flag when the parity bit disagrees with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_last && !w_par_ok;
    end
  end

  assign err = r_err;
`else
  assign w_word   = {sdi, r_shift};
  assign w_par_ok = 1'b1;
`endif

  // collect bits; the last one bypasses the shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt          <= r_bit_cnt + 1'b1;
        r_shift[r_bit_cnt] <= sdi;
      end
    end
  end

  // latch data only changes when a whole good word arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= '0;
    end else if (w_last && w_par_ok) begin
      r_d <= w_word;
    end
  end

  assign w_tmr_load = (r_state == SETUP) || (r_state == GAP);
  assign w_tmr_dec  = (r_state == STROBE_LO) ||
                      (r_state == STROBE_HI);

  strobe_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_load_val(CNT_W'(STROBE_CYCLES - 1)),
    .i_dec     (w_tmr_dec),
    .o_expired (w_expired)
  );

  // load sequence: setup, c1 pulse, gap, c2 pulse, hold
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_last && w_par_ok) w_next = SETUP;
      SETUP:     w_next = STROBE_LO;
      STROBE_LO: if (w_expired) w_next = GAP;
      GAP:       w_next = STROBE_HI;
      STROBE_HI: if (w_expired) w_next = HOLD;
      HOLD:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // state plus outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_c1    <= 1'b0;
      r_c2    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      r_c1    <= (w_next == STROBE_LO);
      r_c2    <= (w_next == STROBE_HI);
      r_done  <= (w_next == HOLD);
    end
  end

  assign sdi_ready = r_ready;
  assign d1        = r_d[0];
  assign d2        = r_d[1];
  assign d3        = r_d[2];
  assign d4        = r_d[3];
  assign c1        = r_c1;
  assign c2        = r_c2;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_latch_loader.sv
// Bench for serial_latch_loader: W=1 and W=3 instances share stimulus
// and are compared each cycle against a timing model of the load.
module tb_serial_latch_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sdi = 1'b0;
  logic sdi_valid = 1'b0;

  logic rdy0, a0, b0, e0, f0, c1_0, c2_0, dn0;
  logic rdy1, a1, b1, e1, f1, c1_1, c2_1, dn1;

  serial_latch_loader #(.STROBE_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .sdi(sdi), .sdi_valid(sdi_valid),
    .sdi_ready(rdy0), .d1(a0), .d2(b0), .d3(e0), .d4(f0),
    .c1(c1_0), .c2(c2_0), .done(dn0)
  );

  serial_latch_loader #(.STROBE_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .sdi(sdi), .sdi_valid(sdi_valid),
    .sdi_ready(rdy1), .d1(a1), .d2(b1), .d3(e1), .d4(f1),
    .c1(c1_1), .c2(c2_1), .done(dn1)
  );

  logic [7:0] got [2];
  assign got[0] = {rdy0, a0, b0, e0, f0, c1_0, c2_0, dn0};
  assign got[1] = {rdy1, a1, b1, e1, f1, c1_1, c2_1, dn1};

  int W_ARR [2] = '{1, 3};

  // model: m_t = cycles since the 4th bit was taken, -1 when idle
  int       m_t [2];
  int       m_n [2];
  logic [3:0] m_bits [2];
  logic [3:0] m_d [2];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] expv(input int i);
    int t, w;
    logic rdy, e_c1, e_c2, e_dn;
    t    = m_t[i];
    w    = W_ARR[i];
    rdy  = (t < 0);
    e_c1 = (t >= 1) && (t < 1 + w);
    e_c2 = (t >= 2 + w) && (t < 2 + 2 * w);
    e_dn = (t == 2 + 2 * w);
    return {rdy, m_d[i][0], m_d[i][1], m_d[i][2], m_d[i][3],
            e_c1, e_c2, e_dn};
  endfunction

  task automatic tick(input logic r, input logic v, input logic b);
    rst = r;
    sdi_valid = v;
    sdi = b;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_t[i] = -1;
        m_n[i] = 0;
        m_d[i] = 4'b0;
      end else if (m_t[i] < 0) begin
        if (v) begin
          m_bits[i][m_n[i]] = b;
          m_n[i] = m_n[i] + 1;
          if (m_n[i] == 4) begin
            m_d[i] = m_bits[i];
            m_n[i] = 0;
            m_t[i] = 0;
          end
        end
      end else begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == 3 + 2 * W_ARR[i]) m_t[i] = -1;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] rv;
    rv = 8'b1000_0000;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got[i] !== rv) begin
        n_err++;
        $display("FAIL reset inst%0d got=%b exp=%b", i, got[i], rv);
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got[i] !== expv(i)) begin
        n_err++;
        $display("FAIL reset_idle inst%0d got=%b exp=%b",
                 i, got[i], expv(i));
      end
    end
  endtask

  task automatic send_word(input string nm, input logic [3:0] w,
                           input int idle);
    for (int c = 0; c < 4 + idle; c++) begin
      if (c < 4) tick(1'b0, 1'b1, w[3-c]);
      else       tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got[i] !== expv(i)) begin
          n_err++;
          $display("FAIL %s inst%0d cyc%0d got=%b exp=%b",
                   nm, i, c, got[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_basic;
    send_word("basic_1011", 4'b1011, 12);
  endtask

  task automatic test_wide;
    int c1n;
    c1n = 0;
    send_word("wide_0110", 4'b0110, 0);
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      c1n += int'(c1_1);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got[i] !== expv(i) || (got[i][2] && got[i][1])) begin
          n_err++;
          $display("FAIL wide inst%0d cyc%0d got=%b exp=%b",
                   i, c, got[i], expv(i));
        end
      end
    end
    n_vec++;
    if (c1n !== 3) begin
      n_err++;
      $display("FAIL wide_c1_len got=%0d exp=3", c1n);
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b1, c[0]);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got[i] !== expv(i)) begin
          n_err++;
          $display("FAIL b2b inst%0d cyc%0d got=%b exp=%b",
                   i, c, got[i], expv(i));
        end
      end
    end
    for (int c = 0; c < 12; c++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    send_word("rst_partial", 4'b1111, 12);
    send_word("rst_strobe", 4'b1001, 2);
    tick(1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({c1_1, a1, b1, e1, f1} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_strobe_lo got=%b exp=00000",
               {c1_1, a1, b1, e1, f1});
    end
    send_word("rst_after", 4'b0101, 12);
  endtask

  task automatic test_random;
    logic r, v, b;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom);
      tick(r, v, b);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got[i] !== expv(i)) begin
          n_err++;
          $display("FAIL random inst%0d cyc%0d got=%b exp=%b",
                   i, c, got[i], expv(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_t[i] = -1;
      m_n[i] = 0;
      m_bits[i] = 4'b0;
      m_d[i] = 4'b0;
    end
    test_reset;
    test_basic;
    test_wide;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
